// File: rtl/regsel_pkg.sv
// Shared encodings for the register-select sequencer: instruction classes,
// decoder source selects and the sequencer state type.
package regsel_pkg;

  localparam logic [1:0] CLS_MOV  = 2'b00;
  localparam logic [1:0] CLS_ALU  = 2'b01;
  localparam logic [1:0] CLS_PUSH = 2'b10;
  localparam logic [1:0] CLS_POP  = 2'b11;

  localparam logic [1:0] OE_SRC_USEQ = 2'b00;
  localparam logic [1:0] OE_SRC_OP0  = 2'b01;
  localparam logic [1:0] OE_SRC_OP1  = 2'b10;
  localparam logic [1:0] OE_SRC_OP2  = 2'b11;

  localparam logic LOAD_SRC_USEQ = 1'b0;
  localparam logic LOAD_SRC_OP0  = 1'b1;

  localparam logic [2:0] SP_REG = 3'd6;

  typedef enum logic [3:0] {
    IDLE,
    MOV,
    ALU_A,
    ALU_B,
    ALU_W,
    PUSH_DEC,
    PUSH_ADDR,
    PUSH_WR,
    POP_ADDR,
    POP_RD,
    POP_INC
  } regsel_seq_state_t;

  // First micro-step for each instruction class.
  function automatic regsel_seq_state_t firstStep(input logic [1:0] cls);
    regsel_seq_state_t nxt;
    case (cls)
      CLS_MOV:  nxt = MOV;
      CLS_ALU:  nxt = ALU_A;
      CLS_PUSH: nxt = PUSH_DEC;
      default:  nxt = POP_ADDR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/regsel_seq.sv
// One-instruction-at-a-time sequencer driving the register-select decoder
// and the ALU / MAR / memory / stack-pointer strobes.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | ready for an instruction; latches operands on accept
// MOV       | drive op1, load op0, done
// ALU_A     | drive op1 into ALU A
// ALU_B     | drive op2 into ALU B
// ALU_W     | ALU result loaded into op0, done
// PUSH_DEC  | pre-decrement stack pointer
// PUSH_ADDR | drive SP into MAR
// PUSH_WR   | drive op0 onto memory write; waits for mem_ack
// POP_ADDR  | drive SP into MAR
// POP_RD    | memory read; op0 loaded on the mem_ack cycle
// POP_INC   | post-increment stack pointer, done
module regsel_seq
  import regsel_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [1:0] instr_class,
  input  logic [2:0] instr_op0,
  input  logic [2:0] instr_op1,
  input  logic [2:0] instr_op2,
  input  logic       mem_ack,
  output logic       rs_oe,
  output logic       rs_load,
  output logic [1:0] rs_oe_src,
  output logic       rs_load_src,
  output logic [2:0] rs_useq_oe,
  output logic [2:0] rs_op0,
  output logic [2:0] rs_op1,
  output logic [2:0] rs_op2,
  output logic       alu_a_load,
  output logic       alu_b_load,
  output logic       alu_oe,
  output logic       mar_load,
  output logic       mem_oe,
  output logic       mem_we,
  output logic       sp_inc,
  output logic       sp_dec,
  output logic       done
);

  regsel_seq_state_t state;
  logic [2:0] opReg0, opReg1, opReg2;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      opReg0 <= 3'd0;
      opReg1 <= 3'd0;
      opReg2 <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            state  <= firstStep(instr_class);
            opReg0 <= instr_op0;
            opReg1 <= instr_op1;
            opReg2 <= instr_op2;
          end
        end
        MOV:       state <= IDLE;
        ALU_A:     state <= ALU_B;
        ALU_B:     state <= ALU_W;
        ALU_W:     state <= IDLE;
        PUSH_DEC:  state <= PUSH_ADDR;
        PUSH_ADDR: state <= PUSH_WR;
        PUSH_WR:   if (mem_ack) state <= IDLE;
        POP_ADDR:  state <= POP_RD;
        POP_RD:    if (mem_ack) state <= POP_INC;
        POP_INC:   state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign rs_op0 = opReg0;
  assign rs_op1 = opReg1;
  assign rs_op2 = opReg2;

  // Pure state decode; only the memory-wait states look at mem_ack.
  always_comb begin
    instr_ready = 1'b0;
    rs_oe       = 1'b0;
    rs_oe_src   = OE_SRC_USEQ;
    rs_load     = 1'b0;
    rs_load_src = LOAD_SRC_USEQ;
    rs_useq_oe  = 3'd0;
    alu_a_load  = 1'b0;
    alu_b_load  = 1'b0;
    alu_oe      = 1'b0;
    mar_load    = 1'b0;
    mem_oe      = 1'b0;
    mem_we      = 1'b0;
    sp_inc      = 1'b0;
    sp_dec      = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: instr_ready = 1'b1;
      MOV: begin
        rs_oe       = 1'b1;
        rs_oe_src   = OE_SRC_OP1;
        rs_load     = 1'b1;
        rs_load_src = LOAD_SRC_OP0;
        done        = 1'b1;
      end
      ALU_A: begin
        rs_oe      = 1'b1;
        rs_oe_src  = OE_SRC_OP1;
        alu_a_load = 1'b1;
      end
      ALU_B: begin
        rs_oe      = 1'b1;
        rs_oe_src  = OE_SRC_OP2;
        alu_b_load = 1'b1;
      end
      ALU_W: begin
        alu_oe      = 1'b1;
        rs_load     = 1'b1;
        rs_load_src = LOAD_SRC_OP0;
        done        = 1'b1;
      end
      PUSH_DEC: sp_dec = 1'b1;
      PUSH_ADDR, POP_ADDR: begin
        rs_oe      = 1'b1;
        rs_oe_src  = OE_SRC_USEQ;
        rs_useq_oe = SP_REG;
        mar_load   = 1'b1;
      end
      PUSH_WR: begin
        rs_oe     = 1'b1;
        rs_oe_src = OE_SRC_OP0;
        mem_we    = 1'b1;
        done      = mem_ack;
      end
      POP_RD: begin
        // The load source only qualifies a load, so it follows mem_ack too.
        mem_oe      = 1'b1;
        rs_load     = mem_ack;
        rs_load_src = mem_ack ? LOAD_SRC_OP0 : LOAD_SRC_USEQ;
      end
      POP_INC: begin
        sp_inc = 1'b1;
        done   = 1'b1;
      end
      default: instr_ready = 1'b0;
    endcase
  end

endmodule
